// File: rtl/fir_sym_mac_if.sv
// Tap-operand and filtered-output bundle of the symmetric FIR MAC.
// The master side supplies taps and observes results; the slave side is the MAC itself.
interface fir_sym_mac_if #(
  parameter int data_width  = 16,
  parameter int coeff_width = 16
);
  logic                          tap_valid;
  logic                          tap_first;
  logic                          tap_last;
  logic                          tap_center;
  logic signed [data_width-1:0]  x_left;
  logic signed [data_width-1:0]  x_right;
  logic signed [coeff_width-1:0] coeff;
  logic signed [data_width-1:0]  y_out;
  logic                          y_valid;
  logic [8:0]                    y_taps;
  logic                          seq_err;

  modport master (
    output tap_valid, tap_first, tap_last, tap_center, x_left, x_right, coeff,
    input  y_out, y_valid, y_taps, seq_err
  );

  modport slave (
    input  tap_valid, tap_first, tap_last, tap_center, x_left, x_right, coeff,
    output y_out, y_valid, y_taps, seq_err
  );
endinterface

// File: rtl/fir_sym_mac.sv
// Symmetric-FIR MAC: pre-adds mirrored samples, multiplies by h[k], accumulates one frame,
// then rounds half-up and saturates to Q1.15. Four register stages, one tap per cycle.
module fir_sym_mac #(
  parameter int data_width  = 16,
  parameter int coeff_width = 16,
  parameter int filter_taps = 317,
  parameter int acc_width   = 42
) (
  input logic          clk,
  input logic          rst,
  fir_sym_mac_if.slave bus
);
  localparam int sum_width  = data_width + 1;
  localparam int prod_width = sum_width + coeff_width;
  localparam int cnt_width  = $clog2(filter_taps + 1);
  localparam int shift      = coeff_width - 1;

  localparam logic signed [acc_width-1:0] round_half =
    {{(acc_width - shift){1'b0}}, 1'b1, {(shift - 1){1'b0}}};
  localparam logic signed [data_width-1:0] y_max = {1'b0, {(data_width - 1){1'b1}}};
  localparam logic signed [data_width-1:0] y_min = {1'b1, {(data_width - 1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                        state;
  logic                          accept;
  logic signed [sum_width-1:0]   pre_sum;

  logic                          s1_valid, s1_first, s1_last;
  logic signed [sum_width-1:0]   s1_sum;
  logic signed [coeff_width-1:0] s1_coeff;

  logic                          s2_valid, s2_first, s2_last;
  logic signed [prod_width-1:0]  s2_prod;

  logic                          s3_done;
  logic signed [acc_width-1:0]   acc;
  logic [cnt_width-1:0]          cnt;

  logic signed [acc_width-1:0]   acc_shf;
  logic signed [data_width-1:0]  y_sat;

  // NOTE: every always_comb output gets a default assignment first so no path can infer a latch.
  always_comb begin
    accept  = bus.tap_valid & (bus.tap_first | (state == ACCUM));
    pre_sum = {bus.x_left[data_width-1], bus.x_left};
    if (!bus.tap_center) begin
      pre_sum = pre_sum + {bus.x_right[data_width-1], bus.x_right};
    end
  end

  // Framing FSM and stage S1. A tap with tap_first in ACCUM restarts the frame; the
  // registered first flag makes S3 reload, so the partial sum never reaches the output.
  // NOTE: all clocked state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.seq_err <= 1'b0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_sum      <= '0;
      s1_coeff    <= '0;
    end else begin
      s1_valid <= accept;
      if (bus.tap_valid) begin
        unique case (state)
          IDLE: begin
            if (!bus.tap_first)    bus.seq_err <= 1'b1;
            else if (!bus.tap_last) state      <= ACCUM;
          end
          ACCUM: begin
            if (bus.tap_first) bus.seq_err <= 1'b1;
            if (bus.tap_last)  state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (accept) begin
        s1_sum   <= pre_sum;
        s1_coeff <= bus.coeff;
        s1_first <= bus.tap_first;
        s1_last  <= bus.tap_last;
      end
    end
  end

  // Stages S2 (full-precision product) and S3 (accumulate); bubbles leave acc untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
      s3_done  <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod  <= prod_width'(s1_sum) * prod_width'(s1_coeff);
        s2_first <= s1_first;
        s2_last  <= s1_last;
      end
      s3_done <= s2_valid & s2_last;
      if (s2_valid) begin
        acc <= s2_first ? acc_width'(s2_prod) : acc + acc_width'(s2_prod);
        cnt <= s2_first ? cnt_width'(1) : cnt + cnt_width'(1);
      end
    end
  end

  // Round half-up, drop the extra fraction bits, clamp when the integer part overflows Q1.15.
  always_comb begin
    acc_shf = (acc + round_half) >>> shift;
    y_sat   = acc_shf[data_width-1:0];
    if (acc_shf[acc_width-1:data_width-1] != {(acc_width - data_width + 1){acc_shf[acc_width-1]}}) begin
      y_sat = acc_shf[acc_width-1] ? y_min : y_max;
    end
  end

  // Stage S4: results hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y_valid <= 1'b0;
      bus.y_out   <= '0;
      bus.y_taps  <= '0;
    end else begin
      bus.y_valid <= s3_done;
      if (s3_done) begin
        bus.y_out  <= y_sat;
        bus.y_taps <= 9'(cnt);
      end
    end
  end
endmodule

// File: tb/tb_fir_sym_mac.sv
// Randomised and directed bench for fir_sym_mac against a frame-level arithmetic model.
// A tap sampled on edge k must produce its y_valid after edge k+3 (four edges counting k).
module tb_fir_sym_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_sym_mac_if bus ();

  fir_sym_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    int          cyc;
    logic [15:0] y;
    logic [8:0]  taps;
  } result_t;

  result_t exp_q[$];
  result_t obs_q[$];

  always @(negedge clk) begin
    if (bus.y_valid) obs_q.push_back('{cyc, bus.y_out, bus.y_taps});
  end

  // Frame-level reference: exact integer sum of products, then round/clamp arithmetically.
  bit     m_in_frame = 1'b0;
  bit     m_seq_err  = 1'b0;
  longint m_acc      = 0;
  int     m_cnt      = 0;

  function automatic logic [15:0] round_sat(input longint a);
    longint q;
    q = (a + 64'sd16384) >>> 15;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  task automatic model_tap(input bit v, f, l, c, input logic [15:0] xl, xr, co, input int edge_cyc);
    longint p;
    if (!v) return;
    p = c ? longint'($signed(xl)) : longint'($signed(xl)) + longint'($signed(xr));
    p = p * longint'($signed(co));
    if (!f && !m_in_frame) begin
      m_seq_err = 1'b1;
      return;
    end
    if (f) begin
      if (m_in_frame) m_seq_err = 1'b1;
      m_acc = p;
      m_cnt = 1;
    end else begin
      m_acc = m_acc + p;
      m_cnt = m_cnt + 1;
    end
    m_in_frame = !l;
    if (l) exp_q.push_back('{edge_cyc + 3, round_sat(m_acc), 9'(m_cnt)});
  endtask

  task automatic drive(input bit v, f, l, c, input logic [15:0] xl, xr, co);
    @(negedge clk);
    bus.tap_valid  = v;
    bus.tap_first  = f;
    bus.tap_last   = l;
    bus.tap_center = c;
    bus.x_left     = xl;
    bus.x_right    = xr;
    bus.coeff      = co;
    model_tap(v, f, l, c, xl, xr, co, cyc + 1);
  endtask

  // Invalid cycles carry random flags and data that the DUT must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_reset();
    bus.tap_valid = 1'b0; bus.tap_first = 1'b0; bus.tap_last = 1'b0; bus.tap_center = 1'b0;
    bus.x_left = '0; bus.x_right = '0; bus.coeff = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.y_out !== 16'h0000) begin n_fail++; $display("FAIL reset y_out: got %h want 0000", bus.y_out); end
    n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset y_valid: got %b want 0", bus.y_valid); end
    n_checks++; if (bus.y_taps !== 9'd0) begin n_fail++; $display("FAIL reset y_taps: got %0d want 0", bus.y_taps); end
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL reset seq_err: got %b want 0", bus.seq_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_tap();
    drive(1, 1, 1, 0, 16'h4000, 16'h4000, 16'h4000);
    idle(2);
    drive(1, 1, 1, 1, 16'h4000, 16'h1234, 16'h4000);
    idle(2);
    drive(1, 1, 1, 0, 16'h0001, 16'h0000, 16'h4000);
    idle(6);
    #1;
    n_checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      n_fail++; $display("FAIL single_tap pulses: got %0d want 3 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_tap result %0d: got cyc=%0d y=%h taps=%0d want cyc=%0d y=%h taps=%0d",
                 i, obs_q[i].cyc, obs_q[i].y, obs_q[i].taps, exp_q[i].cyc, exp_q[i].y, exp_q[i].taps);
      end
    end
    n_checks++; if (obs_q[0].y !== 16'h4000 || obs_q[0].taps !== 9'd1) begin n_fail++; $display("FAIL single_tap value: got y=%h taps=%0d want y=4000 taps=1", obs_q[0].y, obs_q[0].taps); end
    n_checks++; if (obs_q[1].y !== 16'h2000) begin n_fail++; $display("FAIL centre_tap value: got %h want 2000", obs_q[1].y); end
    n_checks++; if (obs_q[2].y !== 16'h0001) begin n_fail++; $display("FAIL rounding value: got %h want 0001", obs_q[2].y); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      logic [15:0] x;
      x = (pass == 0) ? 16'h7FFF : 16'h8000;
      for (int k = 0; k < 159; k++) drive(1, k == 0, k == 158, k == 158, x, x, 16'h7FFF);
      idle(6);
    end
    #1;
    n_checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++; $display("FAIL saturation pulses: got %0d want 2 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL saturation result %0d: got cyc=%0d y=%h taps=%0d want cyc=%0d y=%h taps=%0d",
                 i, obs_q[i].cyc, obs_q[i].y, obs_q[i].taps, exp_q[i].cyc, exp_q[i].y, exp_q[i].taps);
      end
    end
    n_checks++; if (obs_q[0].y !== 16'h7FFF || obs_q[0].taps !== 9'd159) begin n_fail++; $display("FAIL sat_pos value: got y=%h taps=%0d want y=7fff taps=159", obs_q[0].y, obs_q[0].taps); end
    n_checks++; if (obs_q[1].y !== 16'h8000) begin n_fail++; $display("FAIL sat_neg value: got %h want 8000", obs_q[1].y); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) drive(1, k == 0, k == 2, 0, 16'h4000, 16'h4000, 16'h4000);
    drive(1, 1, 1, 1, 16'h4000, 16'h0000, 16'h4000);
    idle(8);
    #1;
    n_checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++; $display("FAIL back_to_back pulses: got %0d want 2 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back result %0d: got cyc=%0d y=%h taps=%0d want cyc=%0d y=%h taps=%0d",
                 i, obs_q[i].cyc, obs_q[i].y, obs_q[i].taps, exp_q[i].cyc, exp_q[i].y, exp_q[i].taps);
      end
    end
    n_checks++; if (obs_q[0].y !== 16'h7FFF || obs_q[1].y !== 16'h2000) begin n_fail++; $display("FAIL back_to_back values: got %h,%h want 7fff,2000", obs_q[0].y, obs_q[1].y); end
    n_checks++; if (bus.y_out !== 16'h2000) begin n_fail++; $display("FAIL back_to_back hold: got %h want 2000", bus.y_out); end
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL back_to_back seq_err: got %b want 0", bus.seq_err); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    for (int fr = 0; fr < 40; fr++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        drive(1, k == 0, k == len - 1, (k == len - 1) && ($urandom_range(0, 1) == 1),
              16'($urandom), 16'($urandom), 16'($urandom));
      end
      idle($urandom_range(0, 2));
    end
    idle(8);
    #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random result %0d: got cyc=%0d y=%h taps=%0d want cyc=%0d y=%h taps=%0d",
                 i, obs_q[i].cyc, obs_q[i].y, obs_q[i].taps, exp_q[i].cyc, exp_q[i].y, exp_q[i].taps);
      end
    end
    n_checks++; if (bus.seq_err !== m_seq_err) begin n_fail++; $display("FAIL random seq_err: got %b want %b", bus.seq_err, m_seq_err); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_seq_err();
    drive(1, 0, 1, 0, 16'h1000, 16'h1000, 16'h4000);
    idle(6);
    #1;
    n_checks++; if (bus.seq_err !== 1'b1 || m_seq_err !== 1'b1) begin n_fail++; $display("FAIL idle_err seq_err: got %b want 1", bus.seq_err); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle_err pulses: got %0d want 0", obs_q.size()); end
    // Restart inside a frame: only the second frame's two taps reach the output.
    drive(1, 1, 0, 0, 16'h2000, 16'h2000, 16'h4000);
    drive(1, 0, 0, 0, 16'h2000, 16'h2000, 16'h4000);
    drive(1, 1, 0, 0, 16'h1000, 16'h1000, 16'h2000);
    drive(1, 0, 1, 0, 16'h1000, 16'h1000, 16'h2000);
    idle(6);
    #1;
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL restart pulses: got %0d want 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    n_checks++;
    if (obs_q[0] !== exp_q[0] || obs_q[0].taps !== 9'd2) begin
      n_fail++;
      $display("FAIL restart result: got cyc=%0d y=%h taps=%0d want cyc=%0d y=%h taps=2",
               obs_q[0].cyc, obs_q[0].y, obs_q[0].taps, exp_q[0].cyc, exp_q[0].y);
    end
    n_checks++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL restart seq_err sticky: got %b want 1", bus.seq_err); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) drive(1, k == 0, k == 2, 0, 16'h3000, 16'h1000, 16'h5000);
    idle(1);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.y_out !== 16'h0000 || bus.y_taps !== 9'd0) begin n_fail++; $display("FAIL mid_reset outputs: got y=%h taps=%0d want 0000/0", bus.y_out, bus.y_taps); end
    n_checks++; if (bus.seq_err !== 1'b0 || bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset flags: got seq_err=%b y_valid=%b want 0/0", bus.seq_err, bus.y_valid); end
    m_in_frame = 1'b0; m_seq_err = 1'b0;
    exp_q.delete();
    bus.tap_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    idle(6);
    #1;
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_reset aborted frame: got %0d pulses want 0", obs_q.size()); end
    // First tap after reset without tap_first is a framing error.
    drive(1, 0, 1, 0, 16'h4000, 16'h4000, 16'h4000);
    drive(1, 1, 1, 0, 16'h0800, 16'h0400, 16'h7000);
    idle(6);
    #1;
    n_checks++; if (bus.seq_err !== m_seq_err || m_seq_err !== 1'b1) begin n_fail++; $display("FAIL post_reset seq_err: got %b want 1", bus.seq_err); end
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL post_reset frame: got %0d pulses y=%h taps=%0d want 1 pulse y=%h taps=%0d",
               obs_q.size(), obs_q[0].y, obs_q[0].taps, exp_q[0].y, exp_q[0].taps);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_tap();
    test_saturation();
    test_back_to_back();
    test_random();
    test_seq_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
